// File: rtl/serial_frame_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_rx_pkg
// Description : Shared definitions for the 3-wire serial byte link
//               (cs/sclk/sdio). Each wire byte is one flag bit followed by
//               eight data bits, MSB first. This package also defines the
//               receiver state encoding.
// Revision    : 1.0  initial release
// ============================================================================
package serial_frame_rx_pkg;

  // Bits on the wire per byte: one flag bit plus the data bits
  localparam int BITS_PER_BYTE = 9;
  localparam int DATA_BITS     = BITS_PER_BYTE - 1;

  // Flag values: 0 opens a frame, 1 continues it
  localparam logic FLAG_FIRST = 1'b0;
  localparam logic FLAG_CONT  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLAG  = 2'd1,
    ST_DATA  = 2'd2,
    ST_ABORT = 2'd3
  } rx_state_e;

endpackage : serial_frame_rx_pkg
`default_nettype wire

// File: rtl/serial_frame_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_rx_if
// Description : Link wires plus the received-byte interface of the serial
//               frame receiver.
//               master : link driver, consumes received bytes and strobes
//               slave  : the receiver
// Ports       : cs, sclk, sdio        link wires (async to the system clock)
//               data_8, data_valid    last received byte and its 1-cycle strobe
//               first_byte            flag of that byte was "first"
//               byte_cnt              bytes accepted in the current frame
//               frame_done, frame_err 1-cycle frame end / framing-error strobes
// Revision    : 1.0  initial release
// ============================================================================
interface serial_frame_rx_if #(
  parameter int CNT_W = 4
);
  logic             cs;
  logic             sclk;
  logic             sdio;
  logic [7:0]       data_8;
  logic             data_valid;
  logic             first_byte;
  logic [CNT_W-1:0] byte_cnt;
  logic             frame_done;
  logic             frame_err;

  modport master (
    output cs, sclk, sdio,
    input  data_8, data_valid, first_byte, byte_cnt, frame_done, frame_err
  );

  modport slave (
    input  cs, sclk, sdio,
    output data_8, data_valid, first_byte, byte_cnt, frame_done, frame_err
  );
endinterface : serial_frame_rx_if
`default_nettype wire

// File: rtl/serial_frame_rx_sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_rx_sync_edge_det
// Description : STAGES-deep synchroniser for one asynchronous input, with
//               rise/fall strobes derived from the synchronised copy.
// Ports       : clk, rst_n  system clock, async active-low reset
//               din          asynchronous input
//               sync         synchronised level
//               rise, fall   1-cycle edge strobes on the synchronised level
// Revision    : 1.0  initial release
// ============================================================================
module serial_frame_rx_sync_edge_det #(
  parameter int STAGES = 2   // must be >= 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] r_chain;
  logic              r_prev;

  // Reset to 0: a cs that is already low when reset releases produces no
  // falling edge, so a frame cut by reset is ignored until cs cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= '0;
      r_prev  <= 1'b0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], din};
      r_prev  <= r_chain[STAGES-1];
    end
  end

  assign sync = r_chain[STAGES-1];
  assign rise = r_chain[STAGES-1] & ~r_prev;
  assign fall = ~r_chain[STAGES-1] & r_prev;

endmodule : serial_frame_rx_sync_edge_det
`default_nettype wire

// File: rtl/serial_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_rx
// Description : Receive end of the 3-wire serial byte link. Oversamples
//               cs/sclk/sdio on clk, deserialises 9-bit wire bytes (flag +
//               8 data bits MSB first), checks framing and presents each byte
//               as a 1-cycle strobe.
// Ports       : clk    system clock, at least 4x the sclk frequency
//               rst_n  asynchronous reset, active low
//               link   serial_frame_rx_if.slave (link wires + byte outputs)
// Revision    : 1.0  initial release
// ============================================================================
module serial_frame_rx
  import serial_frame_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,  // synchroniser depth, minimum 2
  parameter int CNT_W       = 4   // byte counter width, saturating
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_frame_rx_if.slave     link
);

  logic w_cs_sync, w_cs_rise, w_cs_fall;
  logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
  logic w_unused;

  serial_frame_rx_sync_edge_det #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (link.cs),
    .sync (w_cs_sync),
    .rise (w_cs_rise),
    .fall (w_cs_fall)
  );

  serial_frame_rx_sync_edge_det #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (link.sclk),
    .sync (w_sclk_sync),
    .rise (w_sclk_rise),
    .fall (w_sclk_fall)
  );

  assign w_unused = w_sclk_sync ^ w_sclk_fall;

  // sdio goes through a chain of identical depth so the sampled bit lines up
  // with the detected sclk rising edge.
  logic [SYNC_STAGES-1:0] r_sdio_sync;
  logic                   w_sdio;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sdio_sync <= '0;
    else        r_sdio_sync <= {r_sdio_sync[SYNC_STAGES-2:0], link.sdio};
  end

  assign w_sdio = r_sdio_sync[SYNC_STAGES-1];

  // A bit is taken while cs was low up to this cycle; this also accepts an
  // sclk rise that lands in the same synchronised cycle as the cs rise, so a
  // final bit coinciding with cs deassertion still completes its byte.
  logic w_sample;
  assign w_sample = w_sclk_rise & (~w_cs_sync | w_cs_rise);

  rx_state_e        r_state, w_state_nx;
  logic [3:0]       r_bit_cnt, w_bit_cnt_nx;
  logic [7:0]       r_shift, w_shift_nx;
  logic             r_flag, w_flag_nx;
  logic [7:0]       r_data, w_data_nx;
  logic             r_first, w_first_nx;
  logic [CNT_W-1:0] r_byte_cnt, w_byte_cnt_nx;
  logic             r_valid, w_valid_nx;
  logic             r_done, w_done_nx;
  logic             r_err, w_err_nx;

  always_comb begin
    w_state_nx    = r_state;
    w_bit_cnt_nx  = r_bit_cnt;
    w_shift_nx    = r_shift;
    w_flag_nx     = r_flag;
    w_data_nx     = r_data;
    w_first_nx    = r_first;
    w_byte_cnt_nx = r_byte_cnt;
    w_valid_nx    = 1'b0;
    w_done_nx     = 1'b0;
    w_err_nx      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_state_nx    = ST_FLAG;
          w_bit_cnt_nx  = '0;
          w_byte_cnt_nx = '0;
        end
      end

      ST_FLAG: begin
        // cs is checked as a level so a frame whose last bit coincided with
        // the cs rise reports done one cycle after its byte.
        if (w_cs_sync) begin
          w_state_nx = ST_IDLE;
          if (w_sample)                w_err_nx  = 1'b1;
          else if (r_byte_cnt != '0)   w_done_nx = 1'b1;
        end else if (w_sample) begin
          if ((w_sdio == FLAG_CONT  && r_byte_cnt == '0) ||
              (w_sdio == FLAG_FIRST && r_byte_cnt != '0)) begin
            w_err_nx   = 1'b1;
            w_state_nx = ST_ABORT;
          end else begin
            w_flag_nx    = w_sdio;
            w_bit_cnt_nx = '0;
            w_state_nx   = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (w_sample && r_bit_cnt == 4'(DATA_BITS - 1)) begin
          w_data_nx    = {r_shift[6:0], w_sdio};
          w_first_nx   = (r_flag == FLAG_FIRST);
          w_valid_nx   = 1'b1;
          w_bit_cnt_nx = '0;
          w_state_nx   = ST_FLAG;
          if (r_byte_cnt != '1) w_byte_cnt_nx = r_byte_cnt + 1'b1;
        end else if (w_cs_sync) begin
          w_err_nx   = 1'b1;
          w_state_nx = ST_IDLE;
        end else if (w_sample) begin
          w_shift_nx   = {r_shift[6:0], w_sdio};
          w_bit_cnt_nx = r_bit_cnt + 4'd1;
        end
      end

      ST_ABORT: begin
        if (w_cs_sync) w_state_nx = ST_IDLE;
      end

      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_flag     <= 1'b0;
      r_data     <= '0;
      r_first    <= 1'b0;
      r_byte_cnt <= '0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_bit_cnt  <= w_bit_cnt_nx;
      r_shift    <= w_shift_nx;
      r_flag     <= w_flag_nx;
      r_data     <= w_data_nx;
      r_first    <= w_first_nx;
      r_byte_cnt <= w_byte_cnt_nx;
      r_valid    <= w_valid_nx;
      r_done     <= w_done_nx;
      r_err      <= w_err_nx;
    end
  end

  assign link.data_8     = r_data;
  assign link.data_valid = r_valid;
  assign link.first_byte = r_first;
  assign link.byte_cnt   = r_byte_cnt;
  assign link.frame_done = r_done;
  assign link.frame_err  = r_err;

endmodule : serial_frame_rx
`default_nettype wire

// File: tb/tb_serial_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_frame_rx
// Description : Self-checking bench for serial_frame_rx. Frames are described
//               as lists of (flag, data) bytes plus an optional truncated
//               tail; a frame-level model turns each list into the expected
//               sequence of valid/done/err strobes, which a per-cycle compare
//               process matches against the receiver outputs.
// Revision    : 1.0  initial release
// ============================================================================
module tb_serial_frame_rx;

  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;
  localparam int EV_VALID    = 0;
  localparam int EV_DONE     = 1;
  localparam int EV_ERR      = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic       first;
    int         cnt;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int edge_cnt = 0, last_rise_edge = 0, valid_edge = 0, done_edge = 0;
  int n_checks = 0, n_pass = 0;
  int n_valid = 0, n_done = 0, n_err = 0;

  ev_t        exp_q[$];
  logic [7:0] exp_data  = 8'h00;
  logic       exp_first = 1'b0;

  logic       f_flag[$];
  logic [7:0] f_data[$];
  int         part_bits = 0;
  bit         cs_last   = 1'b0;
  int         half      = 20;
  int         phase     = 3;

  serial_frame_rx_if #(.CNT_W(CNT_W)) link ();

  serial_frame_rx #(.SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .link (link)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push_ev(input int kind, input logic [7:0] data, input logic first, input int cnt);
    ev_t e;
    e.kind = kind; e.data = data; e.first = first; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  // Frame-level reference: walk the byte list, apply the flag rules and the
  // saturating count, then decide how the frame ends.
  task automatic model_frame(output int final_cnt);
    int cnt;
    bit aborted;
    cnt = 0; aborted = 1'b0;
    foreach (f_data[i]) begin
      if (!aborted) begin
        if ((f_flag[i] == 1'b1 && cnt == 0) || (f_flag[i] == 1'b0 && cnt != 0)) begin
          push_ev(EV_ERR, 8'h00, 1'b0, cnt);
          aborted = 1'b1;
        end else begin
          if (cnt < CNT_MAX) cnt++;
          push_ev(EV_VALID, f_data[i], !f_flag[i], cnt);
        end
      end
    end
    if (!aborted) begin
      if (part_bits > 0) push_ev(EV_ERR, 8'h00, 1'b0, cnt);
      else if (cnt > 0)  push_ev(EV_DONE, 8'h00, 1'b0, cnt);
    end
    final_cnt = cnt;
  endtask

  // Data changes with sclk falling; the receiver samples on sclk rising.
  task automatic send_bit(input logic b, input bit raise_cs);
    link.sdio = b;
    #(half);
    link.sclk = 1'b1;
    last_rise_edge = edge_cnt;
    if (raise_cs) link.cs = 1'b1;
    #(half);
    link.sclk = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 80) begin
      @(posedge clk);
      n++;
    end
    check("drain_pending_events", exp_q.size(), 0);
    exp_q.delete();
    repeat (8) @(posedge clk);
  endtask

  task automatic run_frame();
    int         final_cnt;
    logic [8:0] w;
    bit         last;
    model_frame(final_cnt);
    @(posedge clk);
    #(phase);
    link.cs = 1'b0;
    #(half);
    foreach (f_data[i]) begin
      w = {f_flag[i], f_data[i]};
      for (int b = 8; b >= 0; b--) begin
        last = cs_last && (part_bits == 0) && (i == f_data.size() - 1) && (b == 0);
        send_bit(w[b], last);
      end
    end
    w = 9'($urandom);
    for (int b = 8; b > 8 - part_bits; b--) send_bit(w[b], 1'b0);
    if (link.cs == 1'b0) begin
      #(half);
      link.cs = 1'b1;
    end
    wait_drain();
    check("frame_byte_cnt", link.byte_cnt, final_cnt);
  endtask

  always @(posedge clk) begin : p_cmp
    ev_t e;
    #1;
    if (rst_n) begin
      if (link.data_valid) begin
        n_valid++;
        valid_edge = edge_cnt;
        check("valid_expected", (exp_q.size() > 0 && exp_q[0].kind == EV_VALID), 1);
        if (exp_q.size() > 0 && exp_q[0].kind == EV_VALID) begin
          e = exp_q.pop_front();
          check("valid_data", link.data_8, e.data);
          check("valid_first", link.first_byte, e.first);
          check("valid_byte_cnt", link.byte_cnt, e.cnt);
          check("valid_latency", edge_cnt - last_rise_edge, SYNC_STAGES + 1);
          exp_data  = e.data;
          exp_first = e.first;
        end
      end
      if (link.frame_done) begin
        n_done++;
        done_edge = edge_cnt;
        check("done_expected", (exp_q.size() > 0 && exp_q[0].kind == EV_DONE), 1);
        if (exp_q.size() > 0 && exp_q[0].kind == EV_DONE) begin
          e = exp_q.pop_front();
          check("done_byte_cnt", link.byte_cnt, e.cnt);
        end
      end
      if (link.frame_err) begin
        n_err++;
        check("err_expected", (exp_q.size() > 0 && exp_q[0].kind == EV_ERR), 1);
        if (exp_q.size() > 0 && exp_q[0].kind == EV_ERR) begin
          e = exp_q.pop_front();
          check("err_byte_cnt", link.byte_cnt, e.cnt);
        end
      end
      if (link.frame_done || link.frame_err)
        check("done_err_exclusive", link.frame_done && link.frame_err, 0);
      check("held_data_8", link.data_8, exp_data);
      check("held_first_byte", link.first_byte, exp_first);
    end
  end

  initial begin : p_main
    int         v0, d0, e0, nb, bad_idx;
    bit         bad;
    logic [8:0] w;

    link.cs = 1'b1; link.sclk = 1'b0; link.sdio = 1'b0;
    #12;
    check("rst_data_8", link.data_8, 0);
    check("rst_data_valid", link.data_valid, 0);
    check("rst_first_byte", link.first_byte, 0);
    check("rst_byte_cnt", link.byte_cnt, 0);
    check("rst_frame_done", link.frame_done, 0);
    check("rst_frame_err", link.frame_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);

    // Single byte 0|A5
    f_flag = '{1'b0}; f_data = '{8'hA5}; part_bits = 0; cs_last = 0; half = 20; phase = 3;
    v0 = n_valid; d0 = n_done; e0 = n_err;
    run_frame();
    check("single_valids", n_valid - v0, 1);
    check("single_done", n_done - d0, 1);
    check("single_err", n_err - e0, 0);
    check("single_data", link.data_8, 8'hA5);
    check("single_first", link.first_byte, 1);
    check("single_cnt", link.byte_cnt, 1);

    // Three bytes 0|12 1|34 1|56
    f_flag = '{1'b0, 1'b1, 1'b1}; f_data = '{8'h12, 8'h34, 8'h56}; half = 30; phase = 7;
    v0 = n_valid; d0 = n_done; e0 = n_err;
    run_frame();
    check("three_valids", n_valid - v0, 3);
    check("three_done", n_done - d0, 1);
    check("three_err", n_err - e0, 0);
    check("three_data", link.data_8, 8'h56);
    check("three_first", link.first_byte, 0);
    check("three_cnt", link.byte_cnt, 3);

    // Truncation: second byte cut after its flag and 5 data bits
    f_flag = '{1'b0}; f_data = '{8'h11}; part_bits = 6; half = 20; phase = 2;
    v0 = n_valid; d0 = n_done; e0 = n_err;
    run_frame();
    check("trunc_valids", n_valid - v0, 1);
    check("trunc_done", n_done - d0, 0);
    check("trunc_err", n_err - e0, 1);
    check("trunc_cnt", link.byte_cnt, 1);
    part_bits = 0;

    // First byte carries flag 1
    f_flag = '{1'b1, 1'b1}; f_data = '{8'h77, 8'h22}; phase = 5;
    v0 = n_valid; d0 = n_done; e0 = n_err;
    run_frame();
    check("flag1_valids", n_valid - v0, 0);
    check("flag1_err", n_err - e0, 1);
    check("flag1_done", n_done - d0, 0);
    check("flag1_cnt", link.byte_cnt, 0);

    // Second byte carries flag 0
    f_flag = '{1'b0, 1'b0, 1'b1}; f_data = '{8'h33, 8'h44, 8'h55}; phase = 8;
    v0 = n_valid; d0 = n_done; e0 = n_err;
    run_frame();
    check("flag0_valids", n_valid - v0, 1);
    check("flag0_err", n_err - e0, 1);
    check("flag0_done", n_done - d0, 0);
    check("flag0_cnt", link.byte_cnt, 1);

    // cs rises together with the final sclk rise
    f_flag = '{1'b0}; f_data = '{8'h9C}; cs_last = 1; phase = 4;
    v0 = n_valid; d0 = n_done; e0 = n_err;
    run_frame();
    check("simul_valids", n_valid - v0, 1);
    check("simul_done", n_done - d0, 1);
    check("simul_done_after_valid", done_edge - valid_edge, 1);
    check("simul_data", link.data_8, 8'h9C);
    cs_last = 0;

    // 17 bytes at sclk = clk/4: count saturates
    f_flag.delete(); f_data.delete();
    for (int i = 0; i < 17; i++) begin
      f_flag.push_back(i == 0 ? 1'b0 : 1'b1);
      f_data.push_back(8'($urandom));
    end
    half = 20; phase = $urandom_range(1, 9);
    v0 = n_valid; d0 = n_done; e0 = n_err;
    run_frame();
    check("sat_valids", n_valid - v0, 17);
    check("sat_cnt", link.byte_cnt, 15);
    check("sat_done", n_done - d0, 1);

    // Reset in the middle of a frame
    half = 20;
    v0 = n_valid; d0 = n_done; e0 = n_err;
    push_ev(EV_VALID, 8'hC3, 1'b1, 1);
    @(posedge clk);
    #4;
    link.cs = 1'b0;
    #(half);
    w = 9'h0C3;
    for (int b = 8; b >= 0; b--) send_bit(w[b], 1'b0);
    w = 9'h15A;
    for (int b = 8; b >= 6; b--) send_bit(w[b], 1'b0);
    check("rstmid_pre_valids", n_valid - v0, 1);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    exp_data = 8'h00; exp_first = 1'b0;
    #1;
    check("rstmid_data_8", link.data_8, 0);
    check("rstmid_valid", link.data_valid, 0);
    check("rstmid_first", link.first_byte, 0);
    check("rstmid_cnt", link.byte_cnt, 0);
    check("rstmid_done", link.frame_done, 0);
    check("rstmid_err", link.frame_err, 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    for (int b = 5; b >= 0; b--) send_bit(w[b], 1'b0);
    #(half);
    link.cs = 1'b1;
    repeat (12) @(posedge clk);
    check("rstmid_post_valids", n_valid - v0, 1);
    check("rstmid_post_done", n_done - d0, 0);
    check("rstmid_post_err", n_err - e0, 0);
    check("rstmid_post_cnt", link.byte_cnt, 0);

    f_flag = '{1'b0}; f_data = '{8'h3C}; part_bits = 0; phase = 6;
    run_frame();
    check("rstmid_recover_data", link.data_8, 8'h3C);

    // Randomized frames
    for (int fr = 0; fr < 30; fr++) begin
      nb = $urandom_range(0, 5);
      bad = ($urandom_range(0, 9) == 0);
      bad_idx = (nb > 0) ? $urandom_range(0, nb - 1) : 0;
      f_flag.delete(); f_data.delete();
      for (int i = 0; i < nb; i++) begin
        f_flag.push_back(i == 0 ? 1'b0 : 1'b1);
        f_data.push_back(8'($urandom));
      end
      if (bad && nb > 0) f_flag[bad_idx] = ~f_flag[bad_idx];
      part_bits = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 8) : 0;
      cs_last   = ($urandom_range(0, 3) == 0);
      half      = 10 * $urandom_range(2, 4);
      phase     = $urandom_range(1, 9);
      run_frame();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_serial_frame_rx
`default_nettype wire
